// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO sequencer: op codes, FSM states, timeout default.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hilo_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MFHI = 3'd3;
    localparam logic [2:0] OP_MFLO = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5;
    localparam logic [2:0] OP_MTLO = 3'd6;

    localparam int TIMEOUT_DEFAULT = 40;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        M_START = 3'd1,
        M_WAIT  = 3'd2,
        D_START = 3'd3,
        D_WAIT  = 3'd4
    } state_t;

endpackage

// File: rtl/hilo_wait_timer.sv
// Wait-state cycle counter with clear/enable and an expired flag at LIMIT-1.
// Latency: count updates on the clock edge; o_expired is decoded from the count register.
// Backpressure: none; the controller decides when to clear or advance.
// Ports: clk/reset, i_clr (synchronous clear), i_en (advance), o_expired (count == LIMIT-1).
module hilo_wait_timer #(
    parameter int LIMIT = 40,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/hilo_ctrl.sv
// Sequencer owning HI/LO: launches multiply/divide units, commits results, serves MF/MT ops.
// Latency: start pulse the cycle after accept; commit on the first WAIT cycle that sees done.
// Backpressure: op_ready only in IDLE; stall asserted for every non-IDLE state.
// Ports: op_valid/op_code/rs_val/rt_val request in; op_ready/stall out; unit_a/unit_b operands and
//        mult_*/div_* start/done/result handshake to the units; hi_out/lo_out architectural state;
//        rd_data/rd_valid for MFHI/MFLO; div_zero_exc and timeout_err single-cycle error pulses.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        op_ready,
    output logic        stall,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        mult_start,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic        div_start,
    input  logic        div_done,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        div_zero_exc,
    output logic        timeout_err
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_hi, r_lo, r_a, r_b, r_rd;
    logic        r_rd_vld, r_dz, r_to;
    logic        w_accept, w_commit_m, w_commit_d, w_timeout;
    logic        w_tmr_clr, w_tmr_en, w_expired;

    assign w_accept = (r_state == IDLE) && op_valid;

    hilo_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_clr   = 1'b1;
        w_tmr_en    = 1'b0;
        w_commit_m  = 1'b0;
        w_commit_d  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (op_valid) begin
                    if (op_code == OP_MULT)                     w_state_nxt = M_START;
                    else if (op_code == OP_DIV && rt_val != '0) w_state_nxt = D_START;
                end
            end
            M_START: w_state_nxt = M_WAIT;
            D_START: w_state_nxt = D_WAIT;
            M_WAIT: begin
                w_tmr_clr = 1'b0;
                if (mult_done) begin
                    w_commit_m  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            D_WAIT: begin
                w_tmr_clr = 1'b0;
                if (div_done) begin
                    w_commit_d  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand latches only load on accept, and accept is only possible in IDLE,
    // so unit_a/unit_b cannot move while stall is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_rd_vld <= 1'b0;
            r_dz     <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_rd_vld <= 1'b0;
            r_dz     <= 1'b0;
            r_to     <= w_timeout;
            if (w_accept) begin
                case (op_code)
                    OP_MULT: begin
                        r_a <= rs_val;
                        r_b <= rt_val;
                    end
                    OP_DIV: begin
                        if (rt_val != '0) begin
                            r_a <= rs_val;
                            r_b <= rt_val;
                        end else begin
                            r_dz <= 1'b1;
                        end
                    end
                    OP_MTHI: r_hi <= rs_val;
                    OP_MTLO: r_lo <= rs_val;
                    // Reads see HI/LO as they stood before this edge.
                    OP_MFHI: begin
                        r_rd     <= r_hi;
                        r_rd_vld <= 1'b1;
                    end
                    OP_MFLO: begin
                        r_rd     <= r_lo;
                        r_rd_vld <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (w_commit_m) begin
                r_hi <= mult_hi;
                r_lo <= mult_lo;
            end else if (w_commit_d) begin
                r_hi <= div_hi;
                r_lo <= div_lo;
            end
        end
    end

    assign op_ready     = (r_state == IDLE);
    assign stall        = (r_state != IDLE);
    assign mult_start   = (r_state == M_START);
    assign div_start    = (r_state == D_START);
    assign unit_a       = r_a;
    assign unit_b       = r_b;
    assign hi_out       = r_hi;
    assign lo_out       = r_lo;
    assign rd_data      = r_rd;
    assign rd_valid     = r_rd_vld;
    assign div_zero_exc = r_dz;
    assign timeout_err  = r_to;

endmodule
